nios2os_gpio_ctrl: RTL and testbench

NIOS2OS_GPIO_CTRL -- requirements
Module: nios2os_gpio_ctrl

---
 rtl/nios2os_gpio_pkg.sv | 17 +
 rtl/nios2os_gpio_sync.sv | 25 ++
 rtl/nios2os_gpio_ctrl.sv | 102 ++++++++++
 tb/tb_nios2os_gpio_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/nios2os_gpio_pkg.sv
// Shared constants for the GPIO controller: register offsets and edge-select encodings.
// Latency: n/a (constants only).
// Backpressure: n/a.
package nios2os_gpio_pkg;

    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_DIRECTION = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK   = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET    = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR    = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/nios2os_gpio_sync.sv
// Two-flop synchronizer for asynchronous pin inputs, synchronous active-high reset.
// Latency: 2 clk cycles.
// Backpressure: none.
module nios2os_gpio_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/nios2os_gpio_ctrl.sv
// Avalon-MM GPIO controller: data/direction/irq-mask/edge-capture registers with set/clear aliases.
// Latency: writes take effect next clk; reads are combinational; edges captured 3 clk after pin change.
// Backpressure: none, zero wait states.
module nios2os_gpio_ctrl
    import nios2os_gpio_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                    EDGE_TYPE   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic [DATA_WIDTH-1:0] oe_port,
    output logic                  irq
);

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wdat;
    logic [DATA_WIDTH-1:0] data_out;
    logic [DATA_WIDTH-1:0] direction;
    logic [DATA_WIDTH-1:0] irq_mask;
    logic [DATA_WIDTH-1:0] edge_cap;
    logic [DATA_WIDTH-1:0] in_sync;
    logic [DATA_WIDTH-1:0] in_prev;
    logic [DATA_WIDTH-1:0] edge_det;
    logic [DATA_WIDTH-1:0] cap_clr;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  unused_wdat;

    assign wr_en       = chipselect && !write_n;
    assign wdat        = writedata[DATA_WIDTH-1:0];
    assign unused_wdat = ^writedata;
    assign cap_clr     = (wr_en && address == ADDR_EDGECAP) ? wdat : '0;

    nios2os_gpio_sync #(
        .WIDTH (DATA_WIDTH)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (in_port),
        .q     (in_sync)
    );

    generate
        if (EDGE_TYPE == EDGE_RISE) begin : g_rise
            assign edge_det = in_sync & ~in_prev;
        end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
            assign edge_det = ~in_sync & in_prev;
        end else begin : g_any
            assign edge_det = in_sync ^ in_prev;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out  <= RESET_VALUE;
            direction <= '0;
            irq_mask  <= '0;
            edge_cap  <= '0;
            in_prev   <= '0;
        end else begin
            in_prev  <= in_sync;
            // A clear and a new edge on the same bit in one cycle keep the bit set
            edge_cap <= (edge_cap & ~cap_clr) | edge_det;
            if (wr_en) begin
                case (address)
                    ADDR_DATA:      data_out  <= wdat;
                    ADDR_OUTSET:    data_out  <= data_out | wdat;
                    ADDR_OUTCLR:    data_out  <= data_out & ~wdat;
                    ADDR_DIRECTION: direction <= wdat;
                    ADDR_IRQMASK:   irq_mask  <= wdat;
                    default:        ;
                endcase
            end
        end
    end

    always_comb begin
        rd_word = '0;
        case (address)
            ADDR_DATA:      rd_word = (data_out & direction) | (in_sync & ~direction);
            ADDR_DIRECTION: rd_word = direction;
            ADDR_IRQMASK:   rd_word = irq_mask;
            ADDR_EDGECAP:   rd_word = edge_cap;
            default:        rd_word = '0;
        endcase
        readdata                 = '0;
        readdata[DATA_WIDTH-1:0] = rd_word;
    end

    assign out_port = data_out;
    assign oe_port  = direction;
    assign irq      = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_nios2os_gpio_ctrl.sv
// Directed bench for nios2os_gpio_ctrl at DATA_WIDTH=4, RESET_VALUE=0, EDGE_TYPE=0 (rising).
module tb_nios2os_gpio_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  in_port;
    logic [3:0]  out_port;
    logic [3:0]  oe_port;
    logic        irq;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] rv;

    nios2os_gpio_ctrl #(
        .DATA_WIDTH  (4),
        .RESET_VALUE (4'h0),
        .EDGE_TYPE   (0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .oe_port    (oe_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Drive a write at a negedge; it lands on the following posedge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 4'h0;
        cycles(3);

        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_out", {28'h0, out_port}, 32'h0);
        check("rst_oe", {28'h0, oe_port}, 32'h0);
        reset = 1'b0;
        cycles(1);

        // Data and direction registers drive the pins
        wr(3'd0, 32'hA);
        wr(3'd1, 32'hF);
        check("data_out", {28'h0, out_port}, 32'hA);
        check("data_oe", {28'h0, oe_port}, 32'hF);
        rd(3'd0, rv);
        check("rd_data_all_out", rv, 32'h0000000A);

        // Set/clear aliases
        wr(3'd4, 32'h1);
        check("outset", {28'h0, out_port}, 32'hB);
        wr(3'd5, 32'h8);
        check("outclr", {28'h0, out_port}, 32'h3);
        rd(3'd4, rv);
        check("rd_outset_zero", rv, 32'h0);

        // Rising edge on bit 1 with it unmasked
        wr(3'd1, 32'h0);
        wr(3'd2, 32'h2);
        rd(3'd2, rv);
        check("rd_irqmask", rv, 32'h2);
        in_port = 4'h2;
        cycles(1);
        check("edge_irq_c1", {31'h0, irq}, 32'h0);
        cycles(1);
        check("edge_irq_c2", {31'h0, irq}, 32'h0);
        cycles(1);
        check("edge_irq_c3", {31'h0, irq}, 32'h1);
        rd(3'd3, rv);
        check("rd_edgecap", rv, 32'h2);
        rd(3'd0, rv);
        check("rd_data_inputs", rv, 32'h2);
        wr(3'd3, 32'h2);
        check("edgecap_clr_irq", {31'h0, irq}, 32'h0);
        rd(3'd3, rv);
        check("edgecap_clr_rd", rv, 32'h0);

        // Edge on bit 0 lands in the same cycle as a clear of bit 0
        in_port = 4'h3;
        cycles(2);
        wr(3'd3, 32'h1);
        rd(3'd3, rv);
        check("set_wins", rv, 32'h1);
        check("masked_no_irq", {31'h0, irq}, 32'h0);
        wr(3'd3, 32'h1);
        rd(3'd3, rv);
        check("clr_after_set", rv, 32'h0);

        // Falling edge is ignored in rising mode
        in_port = 4'h1;
        cycles(4);
        rd(3'd3, rv);
        check("fall_ignored", rv, 32'h0);

        // Mixed direction read-back; rising edges on bits 2,3
        wr(3'd1, 32'h3);
        wr(3'd0, 32'h1);
        in_port = 4'hC;
        cycles(4);
        rd(3'd0, rv);
        check("rd_data_mixed", rv, 32'hD);
        rd(3'd6, rv);
        check("rd_reserved6", rv, 32'h0);
        rd(3'd7, rv);
        check("rd_reserved7", rv, 32'h0);
        rd(3'd3, rv);
        check("edgecap_bits23", rv, 32'hC);
        wr(3'd6, 32'hF);
        rd(3'd1, rv);
        check("reserved_wr_ignored", rv, 32'h3);
        check("reserved_wr_out", {28'h0, out_port}, 32'h1);
        wr(3'd1, 32'hFFFF_FFF5);
        rd(3'd1, rv);
        check("upper_bits_ignored", rv, 32'h5);

        // Reset mid-operation with irq high and a competing write
        wr(3'd2, 32'h4);
        check("irq_before_rst", {31'h0, irq}, 32'h1);
        reset      = 1'b1;
        address    = 3'd0;
        writedata  = 32'hF;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        check("rst_mid_irq", {31'h0, irq}, 32'h0);
        check("rst_mid_out", {28'h0, out_port}, 32'h0);
        check("rst_mid_oe", {28'h0, oe_port}, 32'h0);
        rd(3'd0, rv);
        check("rst_rd_data", rv, 32'h0);
        rd(3'd1, rv);
        check("rst_rd_dir", rv, 32'h0);
        rd(3'd2, rv);
        check("rst_rd_mask", rv, 32'h0);
        rd(3'd3, rv);
        check("rst_rd_edgecap", rv, 32'h0);
        cycles(2);
        reset = 1'b0;
        cycles(1);
        rd(3'd3, rv);
        check("no_edge_after_rst", rv, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
